mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access unit between the single-cycle/multicycle core's load/store path and a 32-bit word-addressed data RAM. Accepts one load or store request at a time, tagged with the decoder's `memSelect` encoding ({signed, size}). Performs lane extraction and sign/zero extension for byte and halfword loads. Performs read-modify-write for byte and halfword stores, and flags misaligned accesses without touching memory.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present; held by the core until accepted.
- `req_ready`  out  1: unit idle and able to accept.
- `req_we`  in  1: 1 = store, 0 = load (decoder `MemW`).
- `req_sel`  in  3: {signed, size}; size 0 = BYTE, 1 = HALF, 2 = WORD, 3 = illegal.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1: one-cycle pulse; request complete.
- `rsp_rdata`  out  32: formatted load data; 0 for stores and errors.
- `rsp_err`  out  1: valid with `rsp_valid`; misaligned or illegal size.
- `mem_en`  out  1: RAM access strobe.
- `mem_we`  out  1: RAM write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W: word address, bits [1:0] forced to 0.
- `mem_wdata`  out  32: full word to write.
- `mem_rdata`  in  32: RAM read data, valid the cycle after a read strobe.

## Operation
- **Handshake**
  - Accept on a rising edge with `req_valid && req_ready`. All request fields are captured on that edge.
  - `req_valid` is ignored while `req_ready` is 0.
  - There is no backpressure on responses.
- **States:** IDLE, READ, LWAIT, WRITE, RESP.
- **Transitions from IDLE on accept**
  - Error → RESP.
  - Load → READ.
  - Sub-word store → READ.
  - Word store → WRITE.
- **Transitions through the remaining states**
  - READ → LWAIT.
  - LWAIT → RESP for a load, WRITE for a store.
  - WRITE → RESP.
  - RESP → IDLE.
- **Memory outputs per state**
  - READ: `mem_en`=1, `mem_we`=0.
  - WRITE: `mem_en`=1, `mem_we`=1.
  - All other states: `mem_en`=0, `mem_we`=0.
- **Error condition:** HALF with `addr[0]`=1, WORD with `addr[1:0]`≠0, or size 3. An error never asserts `mem_en`.
- **Lane selection**
  - Little-endian.
  - Byte n occupies bits [8n+7:8n], with n = `addr[1:0]`.
  - A half occupies [16h+15:16h], with h = `addr[1]`.
- **Loads**
  - Extract the selected lane in LWAIT.
  - Sign-extend if signed=1, else zero-extend.
  - WORD passes through unchanged, and the signed bit is ignored.
  - Register the result into `rsp_rdata`.
- **Sub-word stores**
  - In LWAIT, replace the selected lane of `mem_rdata` with `req_wdata`'s low byte/half. All other lanes are preserved.
  - Register the merged word into `mem_wdata`.
- **Word stores:** `mem_wdata` = `req_wdata`.
- **Reset values:** all outputs and state are 0/IDLE, including `req_ready`=0.
- **`req_ready`** is registered. It rises on the first edge after `reset` deasserts, and is 1 exactly when the state is IDLE.
- **Reset mid-operation**
  - `mem_en` and `mem_we` drop immediately (asynchronous).
  - The pending request is discarded with no response and no write.

## Timing
- Accept edge E0. `rsp_valid` is high during the cycle following the edge below:
  - Error: E1.
  - Word store: E2.
  - Load: E3.
  - Sub-word store: E4.
- `req_ready` reasserts on the edge that ends RESP. Back-to-back accept is therefore possible on that same edge +1.
- Every output is a register output. There are no combinational paths from `req_*` or `mem_rdata` to outputs.

## Structure
- Package `mem_pkg`:
  - Size constants BYTE/HALF/WORD.
  - The `memSelect` bit layout.
  - The state enum.
  - Functions `misaligned(size, addr)` and `lane_merge(word, data, size, addr)`.
- Sub-module `mem_load_align`: combinational lane extract plus sign/zero extend. Inputs are word, addr[1:0], size and signed. Used in LWAIT.

## Test plan
- Load signed byte, addr 0x103, RAM[0x100]=0x80FF1234:
  - `rsp_rdata`=0xFFFFFF80.
  - Repeated as unsigned: 0x00000080.
  - One `mem_en` pulse, `rsp_valid` after E3.
- Load signed half, addr 0x102, same word: `rsp_rdata`=0xFFFF80FF. The unsigned version gives 0x000080FF.
- Store byte 0xAB at 0x101, RAM[0x100]=0x11223344:
  - One read, then one write of 0x1122AB44 at `mem_addr`=0x100.
  - `rsp_valid` after E4, `rsp_err`=0.
- Store word 0xDEADBEEF at 0x200:
  - No read; single write cycle.
  - `rsp_valid` after E2. RAM reads back 0xDEADBEEF.
- Load half at 0x101, then size=3 at 0x100:
  - Each gives `rsp_err`=1 and `rsp_rdata`=0 after E1.
  - `mem_en` never asserted.
  - `req_valid` held while `req_ready`=0 produces no extra accept.
- Assert `reset` during LWAIT of a byte store:
  - `mem_en`=0 immediately; no write, no `rsp_valid`.
  - `req_ready` rises one edge after release.
  - The next word load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access unit: memSelect layout,
// size codes, FSM states and lane manipulation functions.
package mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    // Decoder memSelect encoding: {signed, size}
    typedef struct packed {
        logic       sgn;
        logic [1:0] size;
    } mem_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LWAIT = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        mem_sel_t          sel;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_HALF: return addr[0];
            SZ_WORD: return (addr != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Replace the addressed byte/half of word with the low bits of data
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] word,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [1:0]        size,
                                                     input logic [1:0]        addr);
        logic [DATA_W-1:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{addr, 3'b000} +: 8]     = data[7:0];
            SZ_HALF: res[{addr[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatting: little-endian lane extract plus sign/zero extend.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_word[{i_lane, 3'b000} +: 8];
        w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
        o_data_c = i_word;
        case (i_size)
            SZ_BYTE: o_data_c = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data_c = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data_c = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the core and a word-addressed data RAM: sub-word
// loads are formatted, sub-word stores use read-modify-write, misalignment errors.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_sel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_next;
    req_t              r_req;
    logic              r_err;
    logic              w_accept;
    logic              w_err_in;
    logic              w_mem_en_n;
    logic              w_mem_we_n;
    logic              w_ready_n;
    logic              w_rsp_valid_n;
    logic [DATA_W-1:0] w_load_c;

    assign w_accept = req_valid && req_ready;
    assign w_err_in = (req_sel[1:0] == SZ_ILL) || misaligned(req_sel[1:0], req_addr[1:0]);

    mem_load_align u_align (
        .i_word   (mem_rdata),
        .i_lane   (r_req.lane),
        .i_size   (r_req.sel.size),
        .i_signed (r_req.sel.sgn),
        .o_data_c (w_load_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus next values of the registered control outputs
    always_comb begin
        w_next        = r_state;
        w_mem_en_n    = 1'b0;
        w_mem_we_n    = 1'b0;
        w_ready_n     = 1'b0;
        w_rsp_valid_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err_in) begin
                        w_next = ST_RESP;
                    end else if (req_we && (req_sel[1:0] == SZ_WORD)) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ:  w_next = ST_LWAIT;
            ST_LWAIT: w_next = r_req.we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            ST_RESP: begin
                w_next        = ST_IDLE;
                w_rsp_valid_n = 1'b1;
            end
            default:  w_next = ST_IDLE;
        endcase
        w_mem_en_n = (w_next == ST_READ) || (w_next == ST_WRITE);
        w_mem_we_n = (w_next == ST_WRITE);
        w_ready_n  = (w_next == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req     <= '0;
            r_err     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= w_ready_n;
            rsp_valid <= w_rsp_valid_n;
            rsp_err   <= w_rsp_valid_n && r_err;
            mem_en    <= w_mem_en_n;
            mem_we    <= w_mem_we_n;
            if (w_accept) begin
                r_req     <= '{we: req_we, sel: mem_sel_t'(req_sel),
                               lane: req_addr[1:0], wdata: req_wdata};
                r_err     <= w_err_in;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= req_wdata;
                rsp_rdata <= '0;
            end
            // Read data arrives in LWAIT: format a load or merge a sub-word store
            if (r_state == ST_LWAIT) begin
                if (r_req.we) begin
                    mem_wdata <= lane_merge(mem_rdata, r_req.wdata, r_req.sel.size, r_req.lane);
                end else begin
                    rsp_rdata <= w_load_c;
                end
            end
        end
    end

endmodule
